mem_port_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- The data request is driven from the EX/MEM buffer outputs (MemRead/MemWrite, ALU_result as the address, Read_data as the write data).
- Sequences one variable-latency memory transaction at a time.
- Generates per-requester ready pulses and stall signals that hold the pipeline registers.

---
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and data memory
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, GRANT_IF, GRANT_DM, RESP_IF, RESP_DM} state_t;
  localparam logic [3:0] MAX_B = 4'(MAX_DATA_BURST);
  state_t     state;
  logic [3:0] streak;
  logic       pick_dm;
  logic       pick_if;
  assign pick_dm    = dm_req & (~if_req | (streak != MAX_B));
  assign pick_if    = if_req & ~pick_dm;
  assign if_stall   = if_req & ~if_ready;
  assign pipe_stall = dm_req & ~dm_ready;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE:
          if (pick_dm) begin
            state     <= GRANT_DM;
            streak    <= if_req ? streak + 4'd1 : '0;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (pick_if) begin
            state     <= GRANT_IF;
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        GRANT_IF:
          if (mem_ack) begin
            state    <= RESP_IF;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
          end
        GRANT_DM:
          if (mem_ack) begin
            state    <= RESP_DM;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_rdata <= mem_we ? dm_rdata : mem_rdata;
            dm_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized check of mem_port_arbiter against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          if_req, if_ready, if_stall, dm_req, dm_we, dm_ready, pipe_stall;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  int            tests = 0;
  int            fails = 0;
  int            owner, streak, wait_cnt, p_req, max_dly, now_owner;
  bit            chaos, if_done, dm_done, now_req;
  logic          e_req, e_we, e_ifr, e_dmr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ifd, e_dmd;
  int            order [$];
  always #5 CLK = ~CLK;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .pipe_stall(pipe_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return mem_model.exists(a) ? mem_model[a] : a ^ 32'h5A5A_5A5A;
  endfunction
  task automatic model_reset();
    owner = 0; streak = 0; wait_cnt = 0;
    e_req = 0; e_we = 0; e_ifr = 0; e_dmr = 0;
    e_addr = '0; e_wdata = '0; e_ifd = '0; e_dmd = '0;
  endtask
  task automatic model_step();
    logic we;
    if (e_ifr || e_dmr) begin
      e_ifr = 0; e_dmr = 0; owner = 0;
    end else if (owner != 0) begin
      if (mem_ack) begin
        we = e_we;
        e_req = 0; e_we = 0;
        if (owner == 1) begin
          e_ifr = 1; e_ifd = memval(e_addr);
        end else begin
          e_dmr = 1;
          if (we) mem_model[e_addr] = e_wdata;
          else e_dmd = memval(e_addr);
        end
      end
    end else if (dm_req && (!if_req || streak < MB)) begin
      owner = 2;
      streak = if_req ? ((streak < MB) ? streak + 1 : streak) : 0;
      e_req = 1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
      wait_cnt = $urandom_range(max_dly);
      order.push_back(2);
    end else if (if_req) begin
      owner = 1; streak = 0;
      e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = '0;
      wait_cnt = $urandom_range(max_dly);
      order.push_back(1);
    end
  endtask
  task automatic cycle();
    @(posedge CLK); #1;
    check("mem_req", mem_req, e_req);
    check("mem_we", mem_we, e_we);
    if (e_req) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    check("if_ready", if_ready, e_ifr);
    check("dm_ready", dm_ready, e_dmr);
    check("if_rdata", if_rdata, e_ifd);
    check("dm_rdata", dm_rdata, e_dmd);
    if (!if_req || if_done) begin
      if_req = $urandom_range(99) < p_req;
      if_addr = 32'($urandom_range(15)) << 2;
    end else if (chaos && owner == 1 && e_req && $urandom_range(15) == 0) if_req = 0;
    if_done = e_ifr;
    if (!dm_req || dm_done) begin
      dm_req = $urandom_range(99) < p_req;
      dm_we = 1'($urandom_range(1));
      dm_addr = 32'($urandom_range(15)) << 2;
      dm_wdata = $urandom;
    end else if (chaos && owner == 2 && e_req && $urandom_range(15) == 0) dm_req = 0;
    dm_done = e_dmr;
    mem_ack = 0;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack = 1; mem_rdata = memval(mem_addr);
      end else wait_cnt--;
    end else if (chaos && $urandom_range(7) == 0) mem_ack = 1;
    #1;
    check("if_stall", if_stall, if_req & ~e_ifr);
    check("pipe_stall", pipe_stall, dm_req & ~e_dmr);
    now_owner = owner;
    now_req = e_req;
    model_step();
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_if_ready"}, if_ready, 0);
    check({tag, "_dm_ready"}, dm_ready, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_dm_rdata"}, dm_rdata, 0);
  endtask
  task automatic do_reset();
    RST = 1; if_req = 0; dm_req = 0; mem_ack = 0; if_done = 0; dm_done = 0;
    model_reset();
    @(posedge CLK); #1;
    check_all_zero("rst");
    RST = 0;
  endtask
  task automatic reset_mid_dm();
    int n = 0;
    while (!(now_owner == 2 && now_req) && n < 500) begin
      cycle();
      n++;
    end
    check("rst_found_dm", 64'(now_owner == 2 && now_req), 1);
    check("rst_pre_mem_req", mem_req, 1);
    RST = 1; #1;
    check_all_zero("rst_async");
    if_req = 0; dm_req = 0; if_done = 0; dm_done = 0;
    model_reset();
    mem_ack = 1;
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    check("late_ack_dm_ready", dm_ready, 0);
    check("late_ack_mem_req", mem_req, 0);
    mem_ack = 0;
  endtask
  initial begin
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0; now_owner = 0; now_req = 0;
    p_req = 60; max_dly = 3; chaos = 1;
    do_reset();
    repeat (3000) cycle();
    reset_mid_dm();
    repeat (1000) cycle();
    do_reset();
    p_req = 100; max_dly = 0; chaos = 0;
    order.delete();
    for (int n = 0; n < 200 && order.size() < 10; n++) cycle();
    check("order_len", 64'(order.size()), 10);
    for (int i = 0; i < 10 && i < order.size(); i++)
      check($sformatf("order_%0d", i), 64'(order[i]), (i % (MB + 1) == MB) ? 1 : 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
